seq_mult_ctrl: RTL
==================

SEQ_MULT_CTRL -- requirements
Module: seq_mult_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits, minimum 2.
REQ-002 clk  input  1  the only clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in_valid  input  1  operands a/b are valid.
REQ-005 in_ready  output  1  block accepts operands this cycle.
REQ-006 a  input  WIDTH  unsigned multiplicand.
REQ-007 b  input  WIDTH  unsigned multiplier.
REQ-008 out_valid  output  1  product is valid.
REQ-009 out_ready  input  1  consumer takes the product this cycle.
REQ-010 product  output  2*WIDTH  unsigned a*b, registered.
REQ-011 busy  output  1  high in RUN or DONE.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-013 in_ready SHALL equal (state==IDLE) && !rst; acceptance is in_valid && in_ready.
REQ-014 On the accept edge: acc cleared, mcand loaded with a zero-extended to 2*WIDTH, mplier loaded with b, count cleared, and state moves to RUN.
REQ-015 In each RUN cycle: acc gains mcand if mplier[0]==1; mcand shifts left 1; mplier shifts right 1; count increments.
REQ-016 All addition SHALL be 2*WIDTH bits wide and never overflow; no carry out is kept.
REQ-017 RUN SHALL last exactly WIDTH cycles (macro off), then move to DONE with product <= final acc on the same edge.
REQ-018 out_valid SHALL equal (state==DONE); product SHALL stay stable while out_valid is high.
REQ-019 DONE with out_ready==1 SHALL return to IDLE on that edge; out_valid drops next cycle.
REQ-020 While in RUN or DONE, in_valid SHALL be ignored and no operand is sampled.
REQ-021 Once out_valid drops, product SHALL hold its last value until the next accept.
REQ-022 Latency, macro off, SHALL be WIDTH cycles from accept edge to first out_valid cycle, regardless of operand values.

Reset
REQ-023 rst SHALL override every other input in every state, including mid-RUN and DONE.
REQ-024 After a reset edge: state=IDLE, product=0, out_valid=0, busy=0, acc/mcand/mplier/count=0.
REQ-025 in_ready SHALL be 0 while rst is high and 1 in the first cycle after rst falls.

Configuration
REQ-026 Macro SEQ_MULT_EARLY_TERM_EN SHALL enable early termination.
REQ-027 With the macro, RUN SHALL go to DONE on the edge where the updated mplier becomes 0; latency = index of highest set bit of b + 1.
REQ-028 With the macro and b==0, the accept edge SHALL go directly to DONE with product=0; out_valid rises in the cycle after accept.
REQ-029 Without the macro, latency SHALL be fixed per REQ-022 and there SHALL be no zero-detect logic.
REQ-030 Product values SHALL be identical with and without the macro.

Structure
REQ-031 The shared package seq_mult_pkg SHALL hold the state encoding constants (IDLE=0, RUN=1, DONE=2) and the default WIDTH.
REQ-032 The 2*WIDTH adder SHALL be one sub-module, acc_adder, with combinational inputs x and y and output sum.
REQ-033 The count register SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=8)
REQ-034 a=13, b=11, macro off -> product=143, out_valid 8 cycles after accept, in_ready=0 throughout.
REQ-035 a=255, b=255 -> product=65025 (0xFE01), no overflow.
REQ-036 b=0, a=200 -> product=0; macro off: latency 8; macro on: out_valid in the cycle after accept.
REQ-037 a=7, b=4, macro on -> product=28 at latency 3; macro off -> 28 at latency 8.
REQ-038 out_ready held low 5 cycles in DONE, in_valid pulsed -> product stable, in_ready=0, the new operands are not accepted, IDLE only after out_ready=1.
REQ-039 rst asserted for 1 cycle during the 3rd RUN cycle -> next cycle out_valid=0, product=0, busy=0, in_ready=1; a subsequent 6*9 gives 54.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package seq_mult_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/acc_adder.sv
// Accumulator adder for the shift-add multiplier.
// Sum is truncated to the operand width; callers guarantee no overflow.
module acc_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] sum
);

  assign sum = x + y;

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier with valid/ready handshakes.
// Define SEQ_MULT_EARLY_TERM_EN to stop as soon as the multiplier is exhausted.
module seq_mult_ctrl
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     prod_q, prod_d;

  logic [PW-1:0]     add_y;
  logic [PW-1:0]     add_sum;
  logic [WIDTH-1:0]  mplier_sh;
  logic              accept;
  logic              last_step;

  assign add_y     = mplier_q[0] ? mcand_q : '0;
  assign mplier_sh = mplier_q >> 1;
  assign accept    = in_valid && in_ready;

`ifdef SEQ_MULT_EARLY_TERM_EN
  assign last_step = (mplier_sh == '0)
                  || (count_q == CW'(WIDTH - 1));
`else
  assign last_step = (count_q == CW'(WIDTH - 1));
`endif

  acc_adder #(
    .WIDTH (PW)
  ) u_acc_adder (
    .x   (acc_q),
    .y   (add_y),
    .sum (add_sum)
  );

  // Next-state and datapath update for the IDLE/RUN/DONE sequence
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    prod_d   = prod_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a};
          mplier_d = b;
          count_d  = '0;
          state_d  = RUN;
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (b == '0) begin
            state_d = DONE;
            prod_d  = '0;
          end
`endif
        end
      end
      RUN: begin
        acc_d    = add_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_sh;
        count_d  = count_q + CW'(1);
        if (last_step) begin
          state_d = DONE;
          prod_d  = add_sum;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;

endmodule
